// File: rtl/alu_pkg.sv
// Shared constants for the two-requester ALU arbiter: opcodes, FSM encoding, divider sizing.
// The iterative divider is only built when ALU_ITER_DIV_EN is defined.
package alu_pkg;

    localparam int DATA_W     = 32;
    localparam int OP_W       = 3;
    localparam int DIV_CYCLES = 32;
    localparam int CNT_W      = 6;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

    localparam logic [OP_W-1:0] OP_AND  = 3'b000;
    localparam logic [OP_W-1:0] OP_OR   = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
    localparam logic [OP_W-1:0] OP_DIV  = 3'b011;
    localparam logic [OP_W-1:0] OP_ANDN = 3'b100;
    localparam logic [OP_W-1:0] OP_ORN  = 3'b101;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b110;
    localparam logic [OP_W-1:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DIV  = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; zero flags operand inequality (1 when A != B).
// With ALU_ITER_DIV_EN defined the divide opcode is left to the arbiter's iterative divider.
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [OP_W-1:0]   F,
    output logic [DATA_W-1:0] Y,
    output logic              zero
);

    always_comb begin
        Y = '0;
        case (F)
            OP_AND:  Y = A & B;
            OP_OR:   Y = A | B;
            OP_ADD:  Y = A + B;
`ifdef ALU_ITER_DIV_EN
            OP_DIV:  Y = '0;
`else
            // Divide by zero is forced to all ones so no X ever reaches the result.
            OP_DIV:  Y = (B == '0) ? '1 : (A / B);
`endif
            OP_ANDN: Y = A & ~B;
            OP_ORN:  Y = A | ~B;
            OP_SUB:  Y = A - B;
            OP_SLT:  Y = {{(DATA_W-1){1'b0}}, (A < B)};
            default: Y = '0;
        endcase
    end

    assign zero = (A != B);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter feeding one shared ALU; one operation in flight, result held until taken.
// Define ALU_ITER_DIV_EN to build the 32-cycle restoring divider and the DIV state.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_f,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_f,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_y,
    output logic              rsp_zero,
    output logic              busy
);

    state_t            state;
    state_t            state_next;
    logic              last_grant;
    logic              grant_vld;
    logic              grant_id;
    logic              accept;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [OP_W-1:0]   f_q;
    logic [DATA_W-1:0] alu_y;
    logic              alu_zero;

`ifdef ALU_ITER_DIV_EN
    logic [CNT_W-1:0]  div_cnt;
    logic [DATA_W-1:0] div_rem;
    logic [DATA_W-1:0] div_quo;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W:0]   div_diff;
    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] quo_next;
`endif

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = ~last_grant;
        end else if (req0_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b0;
        end else if (req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
        end
    end

    assign accept     = (state == IDLE) && grant_vld;
    assign req0_ready = rst_n && accept && !grant_id;
    assign req1_ready = rst_n && accept && grant_id;
    assign rsp_valid  = (state == RESP);
    assign busy       = (state != IDLE);

    alu u_alu (
        .A    (a_q),
        .B    (b_q),
        .F    (f_q),
        .Y    (alu_y),
        .zero (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
`ifdef ALU_ITER_DIV_EN
                state_next = (f_q == OP_DIV) ? DIV : RESP;
`else
                state_next = RESP;
`endif
            end
`ifdef ALU_ITER_DIV_EN
            DIV: begin
                if (div_cnt == DIV_LAST) begin
                    state_next = RESP;
                end
            end
`endif
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef ALU_ITER_DIV_EN
    // Restoring step: the dividend is shifted out of the top of div_quo while quotient bits enter below.
    always_comb begin
        div_shift = {div_rem, div_quo[DATA_W-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (div_diff[DATA_W]) begin
            rem_next = div_shift[DATA_W-1:0];
            quo_next = {div_quo[DATA_W-2:0], 1'b0};
        end else begin
            rem_next = div_diff[DATA_W-1:0];
            quo_next = {div_quo[DATA_W-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            div_rem <= '0;
            div_quo <= '0;
        end else if (state == EXEC) begin
            div_cnt <= '0;
            div_rem <= '0;
            div_quo <= a_q;
        end else if (state == DIV) begin
            div_cnt <= div_cnt + 1'b1;
            div_rem <= rem_next;
            div_quo <= quo_next;
        end
    end
`endif

    // Operands are captured at the handshake; results are registered so they stay put through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            a_q        <= '0;
            b_q        <= '0;
            f_q        <= '0;
            rsp_id     <= 1'b0;
            rsp_y      <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= grant_id;
                rsp_id     <= grant_id;
                a_q        <= grant_id ? req1_a : req0_a;
                b_q        <= grant_id ? req1_b : req0_b;
                f_q        <= grant_id ? req1_f : req0_f;
            end
            if (state == EXEC) begin
                rsp_y    <= alu_y;
                rsp_zero <= alu_zero;
            end
`ifdef ALU_ITER_DIV_EN
            if ((state == DIV) && (div_cnt == DIV_LAST)) begin
                rsp_y <= (b_q == '0) ? '1 : quo_next;
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter; expected results are queued at accept and checked at response.
// Latency expectations follow ALU_ITER_DIV_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_alu_arbiter;

`ifdef ALU_ITER_DIV_EN
    localparam int DIV_LAT = 34;
    localparam int RST_AT  = 12;
`else
    localparam int DIV_LAT = 2;
    localparam int RST_AT  = 1;
`endif
    localparam int TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [31:0] req0_a = '0;
    logic [31:0] req0_b = '0;
    logic [2:0]  req0_f = '0;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [31:0] req1_a = '0;
    logic [31:0] req1_b = '0;
    logic [2:0]  req1_f = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_id;
    logic [31:0] rsp_y;
    logic        rsp_zero;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic        id;
        logic [31:0] y;
        logic        zero;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
    } op_t;

    alu_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_f     (req0_f),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_f     (req1_f),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_y      (rsp_y),
        .rsp_zero   (rsp_zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model_y(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        case (f)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd3: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd4: return a & ~b;
            3'd5: return a | ~b;
            3'd6: return a - b;
            3'd7: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_f = f;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_f = f;
        end
    endtask

    // Drives one request, waits for its grant, queues the expected result, then drops valid.
    task automatic send(input bit id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                        output int acc);
        exp_t e;
        drive(id, a, b, f);
        acc = -1;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if ((id ? req1_ready : req0_ready) === 1'b1) begin
                acc = cyc;
                break;
            end
        end
        if (acc >= 0) begin
            e.id = id;
            e.y = model_y(a, b, f);
            e.zero = (a != b);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int at);
        at = -1;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        drive(0, 32'd1, 32'd2, 3'd2);
        drive(1, 32'd3, 32'd4, 3'd2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_ready: got %b%b expected 00", req1_ready, req0_ready);
        end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (rsp_y !== 32'd0) begin errors++; $display("[TB] FAIL reset_rsp_y: got %h expected 0", rsp_y); end
        checks++;
        if (rsp_zero !== 1'b0 || rsp_id !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_zero_id: got %b/%b expected 0/0", rsp_zero, rsp_id);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        int acc, at;
        exp_t e;
        send(0, 32'd5, 32'd7, 3'd2, acc);
        wait_rsp(at);
        checks++;
        if (acc < 0 || at < 0 || (at - acc) != 2) begin
            errors++; $display("[TB] FAIL add_latency: got %0d expected 2 (acc %0d)", at - acc, acc);
        end
        if (sb.size() == 0) begin
            checks++; errors++; $display("[TB] FAIL add_scoreboard: got empty expected 1 entry");
        end else begin
            e = sb.pop_front();
            checks++;
            if (rsp_y !== e.y) begin errors++; $display("[TB] FAIL add_y: got %h expected %h", rsp_y, e.y); end
            checks++;
            if (rsp_zero !== e.zero) begin errors++; $display("[TB] FAIL add_zero: got %b expected %b", rsp_zero, e.zero); end
            checks++;
            if (rsp_id !== e.id) begin errors++; $display("[TB] FAIL add_id: got %b expected %b", rsp_id, e.id); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ops();
        op_t ops[$];
        int acc, at;
        exp_t e;
        ops.push_back('{32'hFFFF_0000, 32'h0F0F_0F0F, 3'd0});
        ops.push_back('{32'h0000_0012, 32'h0000_0021, 3'd1});
        ops.push_back('{32'hFFFF_FFFF, 32'h0000_0002, 3'd2});
        ops.push_back('{32'hFFFF_FFFF, 32'h0000_0003, 3'd3});
        ops.push_back('{32'h0000_F0F0, 32'h0000_FF00, 3'd4});
        ops.push_back('{32'h0000_0000, 32'h0000_0001, 3'd5});
        ops.push_back('{32'h0000_0000, 32'h0000_0001, 3'd6});
        ops.push_back('{32'h0000_0003, 32'h0000_0005, 3'd7});
        ops.push_back('{32'h0000_0005, 32'h0000_0003, 3'd7});
        ops.push_back('{32'h8000_0000, 32'h0000_0001, 3'd7});
        for (int i = 0; i < 4; i++) begin
            ops.push_back('{$urandom, $urandom, 3'($urandom_range(0, 7))});
        end
        foreach (ops[i]) begin
            send(1'(i % 2), ops[i].a, ops[i].b, ops[i].f, acc);
            wait_rsp(at);
            if (acc < 0 || at < 0 || sb.size() == 0) begin
                checks++; errors++; $display("[TB] FAIL ops_%0d_handshake: got acc %0d rsp %0d expected both", i, acc, at);
            end else begin
                e = sb.pop_front();
                checks++;
                if (rsp_y !== e.y || rsp_zero !== e.zero || rsp_id !== e.id) begin
                    errors++;
                    $display("[TB] FAIL ops_%0d f=%0d: got y=%h z=%b id=%b expected y=%h z=%b id=%b",
                             i, ops[i].f, rsp_y, rsp_zero, rsp_id, e.y, e.zero, e.id);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_div(input bit id, input logic [31:0] a, input logic [31:0] b, input string name);
        int acc, at;
        bit busy_ok;
        exp_t e;
        send(id, a, b, 3'd3, acc);
        busy_ok = 1'b1;
        at = -1;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (rsp_valid === 1'b1) begin
                at = cyc;
                break;
            end
        end
        checks++;
        if (acc < 0 || at < 0 || (at - acc) != DIV_LAT) begin
            errors++; $display("[TB] FAIL %s_latency: got %0d expected %0d", name, at - acc, DIV_LAT);
        end
        checks++;
        if (!busy_ok) begin errors++; $display("[TB] FAIL %s_busy: got low expected high throughout", name); end
        if (sb.size() == 0) begin
            checks++; errors++; $display("[TB] FAIL %s_scoreboard: got empty expected 1 entry", name);
        end else begin
            e = sb.pop_front();
            checks++;
            if (rsp_y !== e.y) begin errors++; $display("[TB] FAIL %s_y: got %h expected %h", name, rsp_y, e.y); end
            checks++;
            if (rsp_zero !== e.zero || rsp_id !== e.id) begin
                errors++; $display("[TB] FAIL %s_zero_id: got %b/%b expected %b/%b", name, rsp_zero, rsp_id, e.zero, e.id);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin();
        int grants[$];
        int nrsp;
        exp_t e;
        int exp_grant[4] = '{0, 1, 0, 1};
        do_reset();
        drive(0, 32'd9, 32'd9, 3'd6);
        drive(1, 32'd9, 32'd9, 3'd6);
        nrsp = 0;
        for (int i = 0; i < 60 && nrsp < 4; i++) begin
            @(negedge clk);
            if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
                checks++;
                if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
                    errors++; $display("[TB] FAIL rr_both_ready: got 11 expected one-hot");
                end
                grants.push_back(req1_ready === 1'b1 ? 1 : 0);
                e.id = (req1_ready === 1'b1);
                e.y = model_y(32'd9, 32'd9, 3'd6);
                e.zero = 1'b0;
                sb.push_back(e);
            end
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1 && sb.size() != 0) begin
                e = sb.pop_front();
                nrsp++;
                checks++;
                if (rsp_y !== e.y || rsp_zero !== e.zero || rsp_id !== e.id) begin
                    errors++;
                    $display("[TB] FAIL rr_rsp_%0d: got y=%h z=%b id=%b expected y=%h z=%b id=%b",
                             nrsp, rsp_y, rsp_zero, rsp_id, e.y, e.zero, e.id);
                end
            end
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if (nrsp != 4 || grants.size() < 4) begin
            errors++; $display("[TB] FAIL rr_count: got %0d responses %0d grants expected 4", nrsp, grants.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (grants[k] != exp_grant[k]) begin
                    errors++; $display("[TB] FAIL rr_grant_%0d: got %0d expected %0d", k, grants[k], exp_grant[k]);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int acc, at;
        exp_t e;
        do_reset();
        rsp_ready = 1'b0;
        send(0, 32'h0000_1234, 32'h0000_1234, 3'd1, acc);
        drive(1, 32'hDEAD_BEEF, 32'h0FF0_0FF0, 3'd0);
        wait_rsp(at);
        if (at < 0 || sb.size() == 0) begin
            checks++; errors++; $display("[TB] FAIL hold_start: got rsp %0d expected a response", at);
        end else begin
            e = sb[0];
            for (int k = 0; k < 5; k++) begin
                if (k > 0) @(negedge clk);
                checks++;
                if (rsp_valid !== 1'b1 || rsp_y !== e.y || rsp_zero !== e.zero || rsp_id !== e.id ||
                    req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL hold_%0d: got v=%b y=%h z=%b id=%b rdy=%b%b expected v=1 y=%h z=%b id=%b rdy=00",
                             k, rsp_valid, rsp_y, rsp_zero, rsp_id, req1_ready, req0_ready, e.y, e.zero, e.id);
                end
            end
            @(posedge clk);
            #1 rsp_ready = 1'b1;
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_y !== e.y || req1_ready !== 1'b0) begin
                errors++; $display("[TB] FAIL handshake_cycle: got v=%b y=%h rdy1=%b expected v=1 y=%h rdy1=0",
                                   rsp_valid, rsp_y, req1_ready, e.y);
            end
            @(negedge clk);
            checks++;
            if (req1_ready !== 1'b1) begin
                errors++; $display("[TB] FAIL next_accept: got %b expected 1", req1_ready);
            end else begin
                e.id = 1'b1;
                e.y = model_y(32'hDEAD_BEEF, 32'h0FF0_0FF0, 3'd0);
                e.zero = 1'b1;
                sb.push_back(e);
            end
            @(posedge clk);
            #1 req1_valid = 1'b0;
            wait_rsp(at);
            if (at < 0 || sb.size() == 0) begin
                checks++; errors++; $display("[TB] FAIL pending_rsp: got rsp %0d expected a response", at);
            end else begin
                e = sb.pop_front();
                checks++;
                if (rsp_y !== e.y || rsp_id !== e.id || rsp_zero !== e.zero) begin
                    errors++; $display("[TB] FAIL pending_rsp: got y=%h id=%b z=%b expected y=%h id=%b z=%b",
                                       rsp_y, rsp_id, rsp_zero, e.y, e.id, e.zero);
                end
            end
        end
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_div();
        int acc;
        bit rsp_seen;
        rsp_ready = 1'b1;
        send(1, 32'hFFFF_0000, 32'd3, 3'd3, acc);
        sb.delete();
        repeat (RST_AT - 1) @(posedge clk);
        #3;
        checks++;
        if (acc < 0 || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL abort_inflight: got busy=%b acc=%0d expected busy=1", busy, acc);
        end
        req0_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_ctrl: got busy=%b v=%b rdy=%b%b expected 0 0 00",
                               busy, rsp_valid, req1_ready, req0_ready);
        end
        checks++;
        if (rsp_y !== 32'd0 || rsp_zero !== 1'b0 || rsp_id !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_data: got y=%h z=%b id=%b expected 0 0 0", rsp_y, rsp_zero, rsp_id);
        end
        req0_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        rsp_seen = 1'b0;
        repeat (45) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) rsp_seen = 1'b1;
        end
        checks++;
        if (rsp_seen) begin
            errors++; $display("[TB] FAIL abort_no_rsp: got activity after release expected none");
        end
    endtask

    initial begin
        $display("[TB] starting");
        test_reset();
        test_add();
        test_ops();
        test_div(0, 32'd100, 32'd7, "div");
        test_div(1, 32'd123, 32'd0, "div_zero");
        test_round_robin();
        test_back_to_back();
        test_reset_mid_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
